// File: rtl/app_div_unit.sv
// Three-stage Mitchell approximate divider: magnitude capture, log-domain difference,
// antilog with sign restore. A single global advance stalls every stage together.
module app_div_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic        div_by_zero
);
    logic        advance;

    logic        s1_valid_d, s1_valid_q;
    logic        s1_sign_d, s1_sign_q;
    logic        s1_neg_d, s1_neg_q;
    logic        s1_za_d, s1_za_q;
    logic        s1_zb_d, s1_zb_q;
    logic [15:0] s1_mag_a_d, s1_mag_a_q;
    logic [15:0] s1_mag_b_d, s1_mag_b_q;

    logic        s2_valid_d, s2_valid_q;
    logic        s2_sign_d, s2_sign_q;
    logic        s2_neg_d, s2_neg_q;
    logic        s2_za_d, s2_za_q;
    logic        s2_zb_d, s2_zb_q;
    logic [15:0] s2_m_d, s2_m_q;
    logic [5:0]  s2_e_d, s2_e_q;

    logic        out_valid_d, out_valid_q;
    logic        div_by_zero_d, div_by_zero_q;
    logic [31:0] quotient_d, quotient_q;

    logic [3:0]  ka, kb;
    logic [15:0] fa_full, fb_full, diff;
    logic [5:0]  s3_shift, s3_rshift;
    logic [31:0] s3_raw, s3_signed;

    function automatic logic [3:0] lead_one(input logic [15:0] x);
        logic [3:0] k;
        k = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (x[i]) k = 4'(i);
        end
        return k;
    endfunction

    assign advance     = !out_valid_q || out_ready;
    assign in_ready    = advance;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign div_by_zero = div_by_zero_q;

    always_comb begin : stage1_comb
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_neg_d   = s1_neg_q;
        s1_za_d    = s1_za_q;
        s1_zb_d    = s1_zb_q;
        s1_mag_a_d = s1_mag_a_q;
        s1_mag_b_d = s1_mag_b_q;
        if (advance) begin
            s1_valid_d = in_valid;
            s1_sign_d  = sign;
            s1_neg_d   = sign & (dividend[15] ^ divisor[15]);
            s1_za_d    = (dividend == '0);
            s1_zb_d    = (divisor == '0);
            s1_mag_a_d = (sign && dividend[15]) ? (~dividend + 16'd1) : dividend;
            s1_mag_b_d = (sign && divisor[15])  ? (~divisor + 16'd1)  : divisor;
        end
    end

    always_comb begin : stage2_comb
        ka      = lead_one(s1_mag_a_q);
        kb      = lead_one(s1_mag_b_q);
        fa_full = s1_mag_a_q << (4'd15 - ka);
        fb_full = s1_mag_b_q << (4'd15 - kb);
        // diff[15] is the borrow; it lowers the exponent and wraps the mantissa
        diff    = {1'b0, fa_full[14:0]} - {1'b0, fb_full[14:0]};

        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_neg_d   = s2_neg_q;
        s2_za_d    = s2_za_q;
        s2_zb_d    = s2_zb_q;
        s2_m_d     = s2_m_q;
        s2_e_d     = s2_e_q;
        if (advance) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_neg_d   = s1_neg_q;
            s2_za_d    = s1_za_q;
            s2_zb_d    = s1_zb_q;
            s2_m_d     = {1'b1, diff[14:0]};
            s2_e_d     = {2'b00, ka} - {2'b00, kb} - {5'b0, diff[15]};
        end
    end

    always_comb begin : stage3_comb
        s3_shift  = s2_e_q + 6'd1;
        s3_rshift = 6'd0 - s3_shift;
        if (!s3_shift[5]) s3_raw = {16'b0, s2_m_q} << s3_shift[4:0];
        else              s3_raw = {16'b0, s2_m_q} >> s3_rshift[4:0];
        s3_signed = s2_neg_q ? (~s3_raw + 32'd1) : s3_raw;

        out_valid_d   = out_valid_q;
        div_by_zero_d = div_by_zero_q;
        quotient_d    = quotient_q;
        if (advance) begin
            out_valid_d   = s2_valid_q;
            div_by_zero_d = s2_zb_q;
            if (s2_zb_q) begin
                if (!s2_sign_q)    quotient_d = 32'hFFFF_FFFF;
                else if (s2_neg_q) quotient_d = 32'h8000_0000;
                else               quotient_d = 32'h7FFF_FFFF;
            end else if (s2_za_q) begin
                quotient_d = '0;
            end else begin
                quotient_d = s3_signed;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_neg_q      <= 1'b0;
            s1_za_q       <= 1'b0;
            s1_zb_q       <= 1'b0;
            s1_mag_a_q    <= '0;
            s1_mag_b_q    <= '0;
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_neg_q      <= 1'b0;
            s2_za_q       <= 1'b0;
            s2_zb_q       <= 1'b0;
            s2_m_q        <= '0;
            s2_e_q        <= '0;
            out_valid_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
            quotient_q    <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_neg_q      <= s1_neg_d;
            s1_za_q       <= s1_za_d;
            s1_zb_q       <= s1_zb_d;
            s1_mag_a_q    <= s1_mag_a_d;
            s1_mag_b_q    <= s1_mag_b_d;
            s2_valid_q    <= s2_valid_d;
            s2_sign_q     <= s2_sign_d;
            s2_neg_q      <= s2_neg_d;
            s2_za_q       <= s2_za_d;
            s2_zb_q       <= s2_zb_d;
            s2_m_q        <= s2_m_d;
            s2_e_q        <= s2_e_d;
            out_valid_q   <= out_valid_d;
            div_by_zero_q <= div_by_zero_d;
            quotient_q    <= quotient_d;
        end
    end
endmodule

// File: tb/tb_app_div_unit.sv
// Scoreboard bench for app_div_unit: driver pushes expected results, a separate
// monitor pops and compares whenever a result is taken.
module tb_app_div_unit;
    logic        clk       = 1'b0;
    logic        reset_n   = 1'b1;
    logic        in_valid  = 1'b0;
    logic        sign      = 1'b0;
    logic [15:0] dividend  = '0;
    logic [15:0] divisor   = '0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] quotient;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic        dz;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        got;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          ready_rand = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] held_q = '0;
    logic        held_dz = 1'b0;

    app_div_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sign       (sign),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Reference: Mitchell division done with integer arithmetic on the real values.
    function automatic void ref_div(input logic sg, input logic [15:0] a, input logic [15:0] b,
                                    output logic [31:0] q, output logic dz);
        int     ma, mb, ka, kb, fa, fb, d, m, e, s;
        longint raw;
        logic   neg;
        ma  = (sg && a[15]) ? 65536 - int'(a) : int'(a);
        mb  = (sg && b[15]) ? 65536 - int'(b) : int'(b);
        neg = sg & (a[15] ^ b[15]);
        if (mb == 0) begin
            dz = 1'b1;
            q  = !sg ? 32'hFFFF_FFFF : (neg ? 32'h8000_0000 : 32'h7FFF_FFFF);
            return;
        end
        dz = 1'b0;
        if (ma == 0) begin
            q = '0;
            return;
        end
        ka = 0;
        while ((1 << (ka + 1)) <= ma) ka++;
        kb = 0;
        while ((1 << (kb + 1)) <= mb) kb++;
        fa = (ma - (1 << ka)) << (15 - ka);
        fb = (mb - (1 << kb)) << (15 - kb);
        d  = fa - fb;
        if (d < 0) begin
            m = 65536 + d;
            e = ka - kb - 1;
        end else begin
            m = 32768 + d;
            e = ka - kb;
        end
        s   = e + 1;
        raw = (s >= 0) ? (longint'(m) << s) : (longint'(m) >> (-s));
        if (neg) raw = -raw;
        q = raw[31:0];
    endfunction

    function automatic logic [15:0] rnd_op();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 16'h0000;
        if (r == 1) return 16'h8000;
        return 16'($urandom >> $urandom_range(16, 31));
    endfunction

    task automatic issue(input logic sg, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] q, input logic dz, input bit lat);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        sign     = sg;
        dividend = a;
        divisor  = b;
        for (int t = 0; t < 1000 && !acc; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                sb.push_back('{q: q, dz: dz, cyc: cyc, lat: lat});
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            $display("FAIL issue_timeout: in_ready=%0b required 1 within 1000 cycles", in_ready);
            $fatal(1, "input never accepted");
        end
    endtask

    task automatic drain();
        ready_rand = 1'b0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            $fatal(1, "pipeline did not drain");
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n) begin
                #1;
                checks++;
                if (out_valid !== 1'b0 || quotient !== 32'h0 || div_by_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_outputs: out_valid=%b quotient=%h dbz=%b required 0/00000000/0",
                             out_valid, quotient, div_by_zero);
                end
                stall_prev = 1'b0;
            end else begin
                checks++;
                if (in_ready !== (!out_valid || out_ready)) begin
                    errors++;
                    $display("FAIL in_ready: got %b required %b", in_ready, !out_valid || out_ready);
                end
                if (stall_prev) begin
                    checks++;
                    if (out_valid !== 1'b1 || quotient !== held_q || div_by_zero !== held_dz) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b q=%h dz=%b required v=1 q=%h dz=%b",
                                 out_valid, quotient, div_by_zero, held_q, held_dz);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: q=%h dz=%b with no outstanding operation",
                                 quotient, div_by_zero);
                    end else begin
                        got = sb.pop_front();
                        if (quotient !== got.q || div_by_zero !== got.dz) begin
                            errors++;
                            $display("FAIL result: got q=%h dz=%b required q=%h dz=%b",
                                     quotient, div_by_zero, got.q, got.dz);
                        end
                        if (got.lat) begin
                            checks++;
                            if (cyc != got.cyc + 3) begin
                                errors++;
                                $display("FAIL latency: got %0d cycles required 3", cyc - got.cyc);
                            end
                        end
                    end
                end
                stall_prev = out_valid && !out_ready;
                held_q     = quotient;
                held_dz    = div_by_zero;
            end
        end
    end

    logic        dsg[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 0};
    logic [15:0] da[12]  = '{16'd100, 16'd64, 16'd10, 16'd1, 16'hFFC0, 16'd64, 16'hFFC0,
                             16'h8000, 16'd5, 16'd5, 16'hFFFB, 16'd0};
    logic [15:0] db[12]  = '{16'd10, 16'd4, 16'd100, 16'h8000, 16'd4, 16'hFFFC, 16'hFFFC,
                             16'd1, 16'd0, 16'd0, 16'd0, 16'd7};
    logic [31:0] dq[12]  = '{32'h000A_8000, 32'h0010_0000, 32'h0000_1B00, 32'h0000_0002,
                             32'hFFF0_0000, 32'hFFF0_0000, 32'h0010_0000, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    logic        ddz[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};

    initial begin : driver
        logic [15:0] a, b;
        logic        sg, edz;
        logic [31:0] eq;

        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) issue(dsg[i], da[i], db[i], dq[i], ddz[i], 1'b1);
        drain();

        ready_rand = 1'b1;
        for (int i = 0; i < 160; i++) begin
            if (i >= 8) repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            sg = 1'($urandom_range(0, 1));
            a  = rnd_op();
            b  = rnd_op();
            ref_div(sg, a, b, eq, edz);
            issue(sg, a, b, eq, edz, 1'b0);
        end
        drain();

        for (int i = 0; i < 3; i++) begin
            a = rnd_op();
            b = rnd_op();
            ref_div(1'b0, a, b, eq, edz);
            issue(1'b0, a, b, eq, edz, 1'b0);
        end
        reset_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 16'd100, 16'd10, 32'h000A_8000, 1'b0, 1'b1);
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
